game_level_controller: RTL

//  Game/level FSM for the whack-a-mole datapath, directly upstream of top. Generates the game

---
 rtl/game_level_controller_if.sv | 30 +++
 rtl/game_level_controller.sv | 127 ++++++++++++
 2 files changed

// File: rtl/game_level_controller_if.sv
// ============================================================================
//  game_level_controller_if
//  Player/display bus for the whack-a-mole game/level controller.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface game_level_controller_if;
  logic        start;
  logic        hit;
  logic        game;
  logic [27:0] speed;
  logic [1:0]  seed;
  logic [1:0]  level;
  logic [7:0]  hits;
  logic [6:0]  time_left;
  logic        game_over;

  modport master (
    output start, hit,
    input  game, speed, seed, level, hits, time_left, game_over
  );

  modport slave (
    input  start, hit,
    output game, speed, seed, level, hits, time_left, game_over
  );
endinterface

`default_nettype wire

// File: rtl/game_level_controller.sv
// ============================================================================
//  game_level_controller
//  Game/level FSM: game enable, per-level mole speed, LFSR seed, hit/level/time.
//  Rev 1.0
// ============================================================================
`default_nettype none

module game_level_controller #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned GAME_SECONDS   = 60,
  parameter int unsigned HITS_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL      = 3,
  parameter logic [27:0] BASE_SPEED     = 28'd50_000_000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  game_level_controller_if.slave  bus
);

  localparam int unsigned       c_PRE_W      = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_RELOAD = c_PRE_W'(CLK_HZ - 1);
  localparam logic [6:0]        c_GAME_SECS  = 7'(GAME_SECONDS);
  localparam logic [7:0]        c_HPL        = 8'(HITS_PER_LEVEL);
  localparam logic [1:0]        c_MAX_LEVEL  = 2'(MAX_LEVEL);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_start_q;
  logic [1:0]           r_seed_gen;
  logic [c_PRE_W-1:0]   r_prescaler;
  logic [7:0]           r_level_hits;
  logic                 r_game;
  logic                 r_game_over;
  logic [27:0]          r_speed;
  logic [1:0]           r_seed;
  logic [1:0]           r_level;
  logic [7:0]           r_hits;
  logic [6:0]           r_time_left;
  logic                 w_start_pulse;

  assign w_start_pulse = bus.start & ~r_start_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_start_q    <= 1'b0;
      r_seed_gen   <= 2'd1;
      r_prescaler  <= '0;
      r_level_hits <= 8'd0;
      r_game       <= 1'b0;
      r_game_over  <= 1'b0;
      r_speed      <= BASE_SPEED;
      r_seed       <= 2'd1;
      r_level      <= 2'd0;
      r_hits       <= 8'd0;
      r_time_left  <= c_GAME_SECS;
    end else begin
      r_start_q <= bus.start;
      // Seed source skips zero so the downstream mole LFSR can never lock up
      r_seed_gen <= (r_seed_gen == 2'd3) ? 2'd1 : r_seed_gen + 2'd1;
      r_speed    <= BASE_SPEED >> r_level;

      case (r_state)
        IDLE, GAME_OVER: begin
          if (w_start_pulse) begin
            r_state      <= LOAD;
            r_game_over  <= 1'b0;
            r_hits       <= 8'd0;
            r_level      <= 2'd0;
            r_level_hits <= 8'd0;
            r_prescaler  <= c_PRE_RELOAD;
            r_time_left  <= c_GAME_SECS;
          end
        end
        LOAD: begin
          r_state <= PLAY;
          r_game  <= 1'b1;
          r_seed  <= r_seed_gen;
        end
        PLAY: begin
          if (bus.hit) begin
            if (r_hits != 8'hFF) r_hits <= r_hits + 8'd1;
            if (r_level_hits + 8'd1 == c_HPL) begin
              r_level_hits <= 8'd0;
              if (r_level < c_MAX_LEVEL) r_level <= r_level + 2'd1;
            end else begin
              r_level_hits <= r_level_hits + 8'd1;
            end
          end
          if (r_prescaler == '0) begin
            r_prescaler <= c_PRE_RELOAD;
            r_time_left <= r_time_left - 7'd1;
            if (r_time_left <= 7'd1) begin
              r_state     <= GAME_OVER;
              r_game      <= 1'b0;
              r_game_over <= 1'b1;
            end
          end else begin
            r_prescaler <= r_prescaler - 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_game      <= 1'b0;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign bus.game      = r_game;
  assign bus.game_over = r_game_over;
  assign bus.speed     = r_speed;
  assign bus.seed      = r_seed;
  assign bus.level     = r_level;
  assign bus.hits      = r_hits;
  assign bus.time_left = r_time_left;

endmodule

`default_nettype wire
